// File: rtl/dkong3_rom_loader.sv
// -----------------------------------------------------------------------------
// dkong3_rom_loader
//
// Write-side master of the ROM/PROM download bus. Takes 32-bit words from the
// host bridge data-slot FIFO over a valid/ready handshake. Each word is split
// into bytes, most significant byte first. Every byte produces one O_DN_WR
// strobe, at sequential byte addresses 0..TOTAL_BYTES-1. After each strobe the
// loader idles for WR_GAP cycles, with address and data held.
//
// Parameters
//   TOTAL_BYTES   bytes to download (1..131072, any value, not only x4)
//   WR_GAP        idle cycles after each write strobe (1..15)
//
// Ports
//   I_CLK_24M     in   1   system clock, rising edge
//   I_RESETn      in   1   asynchronous active-low reset
//   I_START       in   1   single-cycle start request (honoured in IDLE/DONE)
//   I_WORD        in   32  download word, bits 31:24 are sent first
//   I_WORD_VALID  in   1   I_WORD is valid
//   O_WORD_READY  out  1   word accepted when VALID & READY on the same edge
//   O_DN_ADDR     out  17  download byte address
//   O_DN_DATA     out  8   download byte
//   O_DN_WR       out  1   one-cycle write strobe
//   O_BUSY        out  1   download in progress
//   O_DONE        out  1   all bytes written; held until the next start
// -----------------------------------------------------------------------------
module dkong3_rom_loader #(
    parameter int TOTAL_BYTES = 98304,
    parameter int WR_GAP      = 3
) (
    input  logic        I_CLK_24M,
    input  logic        I_RESETn,
    input  logic        I_START,
    input  logic [31:0] I_WORD,
    input  logic        I_WORD_VALID,
    output logic        O_WORD_READY,
    output logic [16:0] O_DN_ADDR,
    output logic [7:0]  O_DN_DATA,
    output logic        O_DN_WR,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    // The counter is 18 bits wide, so that a full 131072-byte image can reach its end count.
    localparam logic [17:0] TOTAL_CNT = 18'(TOTAL_BYTES);
    localparam logic [3:0]  GAP_LAST  = 4'(WR_GAP - 1);

    state_t      state_q, state_d;
    logic [17:0] cnt_q,   cnt_d;
    logic [1:0]  idx_q,   idx_d;
    logic [31:0] word_q,  word_d;
    logic [3:0]  gap_q,   gap_d;
    logic        ready_q, ready_d;
    logic [16:0] addr_q,  addr_d;
    logic [7:0]  data_q,  data_d;
    logic        wr_q,    wr_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic        transfer;
    logic [7:0]  word_bytes [4];

    // Byte lanes of the latched word. Lane 3 is bits 31:24.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_bytes[gi] = word_q[8*gi +: 8];
    end

    assign transfer = (state_q == S_WAIT_WORD) && ready_q && I_WORD_VALID;

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        gap_d   = gap_q;
        ready_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (I_START) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_WORD;
                end
            end
            S_WAIT_WORD: begin
                // READY is registered from the state. It rises one cycle after
                // the loader enters WAIT_WORD. It falls on the edge that accepts a word.
                ready_d = 1'b1;
                if (transfer) begin
                    word_d  = I_WORD;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                addr_d  = cnt_q[16:0];
                data_d  = word_bytes[~idx_q];   // ~idx is 3-idx for 2 bits
                wr_d    = 1'b1;
                cnt_d   = cnt_q + 18'd1;
                gap_d   = GAP_LAST;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (cnt_q == TOTAL_CNT) begin
                    // Bytes of the current word that are not yet sent are dropped.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == 2'd3) begin
                    state_d = S_WAIT_WORD;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign O_WORD_READY = ready_q;
    assign O_DN_ADDR    = addr_q;
    assign O_DN_DATA    = data_q;
    assign O_DN_WR      = wr_q;
    assign O_BUSY       = busy_q;
    assign O_DONE       = done_q;

endmodule

// File: tb/tb_dkong3_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_dkong3_rom_loader
//
// This bench drives the loader with TOTAL_BYTES=6 and WR_GAP=3.
// The first download sends two words, and only 6 of their 8 bytes are written.
// The expected strobe stream is held in a table of {word, cycle offset, addr, data} records.
// Hand-written sequences cover these cases:
//   - the READY return time
//   - a VALID stall
//   - a START pulse during a gap
//   - DONE behaviour and restart
//   - an asynchronous reset during a strobe
// -----------------------------------------------------------------------------
module tb_dkong3_rom_loader;

    localparam int TB_TOTAL = 6;
    localparam int TB_GAP   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] word;
    logic        valid;
    logic        ready;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        busy;
    logic        done;

    dkong3_rom_loader #(
        .TOTAL_BYTES (TB_TOTAL),
        .WR_GAP      (TB_GAP)
    ) dut (
        .I_CLK_24M    (clk),
        .I_RESETn     (rst_n),
        .I_START      (start),
        .I_WORD       (word),
        .I_WORD_VALID (valid),
        .O_WORD_READY (ready),
        .O_DN_ADDR    (dn_addr),
        .O_DN_DATA    (dn_data),
        .O_DN_WR      (dn_wr),
        .O_BUSY       (busy),
        .O_DONE       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Strobe monitor. It samples 1 time unit after each rising edge.
    typedef struct {
        int          c;
        logic [16:0] a;
        logic [7:0]  d;
    } rec_t;
    rec_t q[$];
    logic prev_wr = 1'b0;

    always @(posedge clk) begin
        #1;
        if (dn_wr === 1'b1) begin
            q.push_back('{cyc, dn_addr, dn_data});
            $display("strobe cycle %0d addr %0d data 0x%02h", cyc, dn_addr, dn_data);
            check("no_back_to_back", {31'b0, prev_wr}, 32'd0);
            check("addr_in_range", {31'b0, (dn_addr < 17'(TB_TOTAL))}, 32'd1);
        end
        prev_wr <= dn_wr;
    end

    // Expected strobe stream of the first download.
    typedef struct {
        int          wsel;   // 0: first word, 1: second word
        int          off;    // cycles after that word's transfer edge
        logic [16:0] addr;
        logic [7:0]  data;
    } vec_t;
    vec_t vecs[6];

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) check("wait_cyc_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, output int n);
        n = -1;
        @(negedge clk);
        word  = w;
        valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (ready === 1'b1) begin
                @(posedge clk);
                #1;
                n = cyc;
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        if (n < 0) check("word_accept_timeout", 32'd0, 32'd1);
        else $display("word 0x%08h accepted at edge %0d", w, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n1, n2, n3, n4, base;

        vecs[0] = '{0,  1, 17'd0, 8'hA1};
        vecs[1] = '{0,  5, 17'd1, 8'hB2};
        vecs[2] = '{0,  9, 17'd2, 8'hC3};
        vecs[3] = '{0, 13, 17'd3, 8'hD4};
        vecs[4] = '{1,  1, 17'd4, 8'h55};
        vecs[5] = '{1,  5, 17'd5, 8'h66};

        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        word  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_wr",    {31'b0, dn_wr}, 32'd0);
        check("reset_addr",  {15'b0, dn_addr}, 32'd0);
        check("reset_data",  {24'b0, dn_data}, 32'd0);
        check("reset_busy",  {31'b0, busy}, 32'd0);
        check("reset_done",  {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A word offered in IDLE must not be taken.
        @(negedge clk);
        word  = 32'h12345678;
        valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_low", {31'b0, ready}, 32'd0);
        valid = 1'b0;

        do_start(s);
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_done", {31'b0, done}, 32'd0);
        q.delete();

        send_word(32'hA1B2C3D4, n1);
        wait_cyc(n1 + 16);
        check("ready_low_before_return", {31'b0, ready}, 32'd0);
        wait_cyc(n1 + 17);
        check("ready_return_n17", {31'b0, ready}, 32'd1);

        // VALID stays low for 10 cycles in WAIT_WORD.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_wr",    {31'b0, dn_wr}, 32'd0);
            check("stall_addr",  {15'b0, dn_addr}, 32'd3);
            check("stall_data",  {24'b0, dn_data}, 32'hD4);
            check("stall_ready", {31'b0, ready}, 32'd1);
        end

        send_word(32'h55667788, n2);
        // Edge n2+7 falls in the gap after byte 1. The START pulse must be ignored.
        wait_cyc(n2 + 6);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("gap_start_busy", {31'b0, busy}, 32'd1);
        check("gap_start_done", {31'b0, done}, 32'd0);
        wait_cyc(n2 + 8);
        check("final_done",  {31'b0, done}, 32'd1);
        check("final_busy",  {31'b0, busy}, 32'd0);
        check("final_ready", {31'b0, ready}, 32'd0);

        check("strobe_count", q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            base = (vecs[i].wsel == 0) ? n1 : n2;
            if (i < q.size()) begin
                check($sformatf("vec%0d_cycle", i), q[i].c, base + vecs[i].off);
                check($sformatf("vec%0d_addr", i), {15'b0, q[i].a}, {15'b0, vecs[i].addr});
                check($sformatf("vec%0d_data", i), {24'b0, q[i].d}, {24'b0, vecs[i].data});
            end else begin
                check($sformatf("vec%0d_missing", i), 32'd0, 32'd1);
            end
        end

        // A word offered in DONE is not accepted, and no further bytes are written.
        @(negedge clk);
        word  = 32'hDEADBEEF;
        valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("done_ready_low", {31'b0, ready}, 32'd0);
        valid = 1'b0;
        check("done_no_more_strobes", q.size(), 32'd6);
        check("done_held", {31'b0, done}, 32'd1);

        // Restart after DONE.
        do_start(s);
        check("restart_done_clear", {31'b0, done}, 32'd0);
        check("restart_busy", {31'b0, busy}, 32'd1);
        q.delete();
        send_word(32'hCAFEBABE, n3);
        wait_cyc(n3 + 1);
        check("restart_first_count", q.size(), 32'd1);
        if (q.size() > 0) begin
            check("restart_first_addr", {15'b0, q[0].a}, 32'd0);
            check("restart_first_data", {24'b0, q[0].d}, 32'hCA);
        end

        // Asynchronous reset while a strobe is high.
        wait_cyc(n3 + 5);
        check("pre_reset_wr",   {31'b0, dn_wr}, 32'd1);
        check("pre_reset_addr", {15'b0, dn_addr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_wr",    {31'b0, dn_wr}, 32'd0);
        check("async_reset_addr",  {15'b0, dn_addr}, 32'd0);
        check("async_reset_data",  {24'b0, dn_data}, 32'd0);
        check("async_reset_busy",  {31'b0, busy}, 32'd0);
        check("async_reset_ready", {31'b0, ready}, 32'd0);
        check("async_reset_done",  {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_start(s);
        q.delete();
        send_word(32'h0F1E2D3C, n4);
        wait_cyc(n4 + 1);
        check("post_reset_count", q.size(), 32'd1);
        if (q.size() > 0) begin
            check("post_reset_addr", {15'b0, q[0].a}, 32'd0);
            check("post_reset_data", {24'b0, q[0].d}, 32'h0F);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
